// File: rtl/wb_commit_buffer.sv
// Writeback/commit stage: DEPTH-entry in-order buffer between MEM and the
// register files, with a registered commit port and an ID forwarding lookup.
module wb_commit_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_rf_we,
    input  logic [ADDR_W-1:0] in_rf_waddr,
    input  logic [DATA_W-1:0] in_rf_wdata,
    input  logic              in_hi_we,
    input  logic              in_lo_we,
    input  logic [DATA_W-1:0] in_hi_data,
    input  logic [DATA_W-1:0] in_lo_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              hi_we,
    output logic              lo_we,
    output logic [DATA_W-1:0] hi_wdata,
    output logic [DATA_W-1:0] lo_wdata,
    input  logic [ADDR_W-1:0] qry_addr,
    output logic              qry_hit,
    output logic [DATA_W-1:0] qry_data,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [PC_W-1:0]   debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [ADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              rf_we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              hi_we;
        logic              lo_we;
        logic [DATA_W-1:0] hi_data;
        logic [DATA_W-1:0] lo_data;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            out_q, out_d;
    entry_t            in_entry_s;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic              push_s, pop_s;
    logic [PTR_W-1:0]  qidx_s [DEPTH];
    logic              qry_hit_s;
    logic [DATA_W-1:0] qry_data_s;

    assign in_ready = (count_q < DEPTH_C);
    assign push_s   = in_valid && in_ready && !flush;
    assign pop_s    = (count_q != '0) && !stall && !flush;

    // A write to r0 is architecturally a no-op, so never store it as a GPR write.
    assign in_entry_s = '{
        pc:      in_pc,
        rf_we:   in_rf_we && (in_rf_waddr != '0),
        waddr:   in_rf_waddr,
        wdata:   in_rf_wdata,
        hi_we:   in_hi_we,
        lo_we:   in_lo_we,
        hi_data: in_hi_data,
        lo_data: in_lo_data
    };

    // Next-state for pointers, occupancy, commit register and retire counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        retire_d = retire_q;
        out_d    = '0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
            rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
            count_d  = count_q + CW'(push_s) - CW'(pop_s);
            out_d    = pop_s ? mem_q[rd_ptr_q] : '0;
            retire_d = (pop_s && mem_q[rd_ptr_q].rf_we) ? (retire_q + CNT_W'(1)) : retire_q;
        end
    end

    // Control and commit state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            retire_q <= '0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            retire_q <= retire_d;
            out_q    <= out_d;
        end
    end

    // Entry storage; contents are only meaningful inside [rd_ptr, rd_ptr+count).
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_q[wr_ptr_q] <= in_entry_s;
        end
    end

    // Forwarding lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        qry_hit_s  = out_q.rf_we && (out_q.waddr == qry_addr);
        qry_data_s = qry_hit_s ? out_q.wdata : '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            qidx_s[i] = rd_ptr_q + PTR_W'(i);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if ((CW'(i) < count_q) && mem_q[qidx_s[i]].rf_we
                && (mem_q[qidx_s[i]].waddr == qry_addr)) begin
                qry_hit_s  = 1'b1;
                qry_data_s = mem_q[qidx_s[i]].wdata;
            end else begin
                qry_hit_s  = qry_hit_s;
                qry_data_s = qry_data_s;
            end
        end
        if (qry_addr == '0) begin
            qry_hit_s  = 1'b0;
            qry_data_s = '0;
        end else begin
            qry_hit_s  = qry_hit_s;
            qry_data_s = qry_data_s;
        end
    end

    assign qry_hit           = qry_hit_s;
    assign qry_data          = qry_data_s;
    assign rf_we             = out_q.rf_we;
    assign rf_waddr          = out_q.waddr;
    assign rf_wdata          = out_q.wdata;
    assign hi_we             = out_q.hi_we;
    assign lo_we             = out_q.lo_we;
    assign hi_wdata          = out_q.hi_data;
    assign lo_wdata          = out_q.lo_data;
    assign retire_cnt        = retire_q;
    assign debug_wb_pc       = out_q.pc;
    assign debug_wb_rf_wen   = {4{out_q.rf_we}};
    assign debug_wb_rf_wnum  = out_q.waddr;
    assign debug_wb_rf_wdata = out_q.wdata;

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Directed bench for wb_commit_buffer (DEPTH=2, CNT_W=4 so retire wrap is reachable).
module tb_wb_commit_buffer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, flush, stall, in_valid, in_ready;
    logic [PC_W-1:0]   in_pc;
    logic              in_rf_we, in_hi_we, in_lo_we;
    logic [ADDR_W-1:0] in_rf_waddr;
    logic [DATA_W-1:0] in_rf_wdata, in_hi_data, in_lo_data;
    logic              rf_we, hi_we, lo_we, qry_hit;
    logic [ADDR_W-1:0] rf_waddr, qry_addr, debug_wb_rf_wnum;
    logic [DATA_W-1:0] rf_wdata, hi_wdata, lo_wdata, qry_data, debug_wb_rf_wdata;
    logic [CNT_W-1:0]  retire_cnt;
    logic [PC_W-1:0]   debug_wb_pc;
    logic [3:0]        debug_wb_rf_wen;

    int n_vec = 0;
    int n_err = 0;

    wb_commit_buffer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_rf_wdata(in_rf_wdata),
        .in_hi_we(in_hi_we), .in_lo_we(in_lo_we),
        .in_hi_data(in_hi_data), .in_lo_data(in_lo_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .qry_addr(qry_addr), .qry_hit(qry_hit), .qry_data(qry_data),
        .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance through one rising edge; inputs change and outputs are sampled at the falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_pc = '0; in_rf_we = 1'b0; in_rf_waddr = '0;
        in_rf_wdata = '0; in_hi_we = 1'b0; in_lo_we = 1'b0;
        in_hi_data = '0; in_lo_data = '0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic we, input logic [4:0] a,
                         input logic [31:0] d);
        idle();
        in_valid = 1'b1; in_pc = pc; in_rf_we = we; in_rf_waddr = a; in_rf_wdata = d;
    endtask

    // Streams n entries back to back (push and pop in the same cycle) then drains.
    task automatic burst(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            drive(32'h1000 + 32'(k * 4), 1'b1, 5'd4, base + 32'(k));
            cyc();
            if (k > 0) check("burst_data", 64'(rf_wdata), 64'(base + 32'(k - 1)));
        end
        idle();
        cyc();
        check("burst_last", 64'(rf_wdata), 64'(base + 32'(n - 1)));
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; qry_addr = '0;
        idle();
        cyc(); cyc();
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_rfwe", 64'(rf_we), 64'd0);
        check("rst_cnt", 64'(retire_cnt), 64'd0);
        check("rst_pc", 64'(debug_wb_pc), 64'd0);
        rst = 1'b0;

        // Single entry: commit appears in the second cycle after the push edge, for one cycle.
        drive(32'hBFC0_0000, 1'b1, 5'd3, 32'h1234_5678);
        qry_addr = 5'd3;
        cyc();
        idle();
        #1;
        check("t1_c1_rfwe", 64'(rf_we), 64'd0);
        check("t1_fwd_buf", 64'(qry_data), 64'h1234_5678);
        cyc();
        check("t1_rfwe", 64'(rf_we), 64'd1);
        check("t1_waddr", 64'(rf_waddr), 64'd3);
        check("t1_wdata", 64'(debug_wb_rf_wdata), 64'h1234_5678);
        check("t1_wen", 64'(debug_wb_rf_wen), 64'hF);
        check("t1_pc", 64'(debug_wb_pc), 64'hBFC0_0000);
        check("t1_cnt", 64'(retire_cnt), 64'd1);
        check("t1_fwd_out", 64'(qry_hit), 64'd1);
        cyc();
        check("t1_pulse", 64'(rf_we), 64'd0);
        check("t1_pc0", 64'(debug_wb_pc), 64'd0);
        check("t1_nohit", 64'(qry_hit), 64'd0);

        // Stall: fill both entries, third push blocked, then drain in order.
        stall = 1'b1;
        drive(32'h100, 1'b1, 5'd1, 32'h11); #1;
        check("t2_rdy0", 64'(in_ready), 64'd1);
        cyc();
        drive(32'h104, 1'b1, 5'd2, 32'h22); #1;
        check("t2_rdy1", 64'(in_ready), 64'd1);
        cyc();
        drive(32'h108, 1'b1, 5'd6, 32'h33); #1;
        check("t2_full", 64'(in_ready), 64'd0);
        check("t2_stall_rfwe", 64'(rf_we), 64'd0);
        cyc();
        idle(); stall = 1'b0;
        cyc();
        check("t2_c0_pc", 64'(debug_wb_pc), 64'h100);
        check("t2_c0_data", 64'(rf_wdata), 64'h11);
        check("t2_rdy_back", 64'(in_ready), 64'd1);
        cyc();
        check("t2_c1_pc", 64'(debug_wb_pc), 64'h104);
        check("t2_c1_waddr", 64'(rf_waddr), 64'd2);
        check("t2_cnt", 64'(retire_cnt), 64'd3);
        cyc();
        check("t2_blocked_gone", 64'(debug_wb_pc), 64'd0);

        // Write to r0 is sanitised: commit cycle without a GPR strobe.
        qry_addr = 5'd0;
        drive(32'h200, 1'b1, 5'd0, 32'hFFFF_FFFF);
        cyc();
        idle(); #1;
        check("t3_qry0", 64'(qry_hit), 64'd0);
        cyc();
        check("t3_rfwe", 64'(rf_we), 64'd0);
        check("t3_pc", 64'(debug_wb_pc), 64'h200);
        check("t3_wen", 64'(debug_wb_rf_wen), 64'd0);
        check("t3_cnt", 64'(retire_cnt), 64'd3);
        cyc();

        // Forwarding picks the youngest of two writes to the same register.
        stall = 1'b1;
        drive(32'h300, 1'b1, 5'd5, 32'hA); cyc();
        drive(32'h304, 1'b1, 5'd5, 32'hB); cyc();
        idle(); qry_addr = 5'd5; #1;
        check("t4_hit", 64'(qry_hit), 64'd1);
        check("t4_young", 64'(qry_data), 64'hB);
        qry_addr = 5'd6; #1;
        check("t4_miss_data", 64'(qry_data), 64'd0);
        qry_addr = 5'd5;
        stall = 1'b0;
        cyc();
        stall = 1'b1; #1;
        check("t4_commitA", 64'(rf_wdata), 64'hA);
        check("t4_still_B", 64'(qry_data), 64'hB);
        cyc();
        check("t4_held_B", 64'(qry_data), 64'hB);
        check("t4_no_repeat", 64'(rf_we), 64'd0);
        stall = 1'b0;
        cyc();
        check("t4_commitB", 64'(rf_wdata), 64'hB);
        check("t4_cnt", 64'(retire_cnt), 64'd5);
        cyc();

        // Flush with a full buffer, then flush that drops a same-cycle push.
        stall = 1'b1;
        drive(32'h500, 1'b1, 5'd7, 32'h77); cyc();
        drive(32'h504, 1'b1, 5'd8, 32'h88); cyc();
        drive(32'h508, 1'b1, 5'd9, 32'h99); flush = 1'b1;
        cyc();
        flush = 1'b0; idle(); stall = 1'b0; qry_addr = 5'd7; #1;
        check("t5_ready", 64'(in_ready), 64'd1);
        check("t5_qry7", 64'(qry_hit), 64'd0);
        cyc();
        check("t5_nocommit0", 64'(debug_wb_pc), 64'd0);
        cyc();
        check("t5_nocommit1", 64'(rf_we), 64'd0);
        stall = 1'b1;
        drive(32'h510, 1'b1, 5'd9, 32'h99); cyc();
        drive(32'h514, 1'b1, 5'd10, 32'hAA); flush = 1'b1; #1;
        check("t5_rdy_flush", 64'(in_ready), 64'd1);
        cyc();
        flush = 1'b0; idle(); stall = 1'b0; qry_addr = 5'd10; #1;
        check("t5_dropped", 64'(qry_hit), 64'd0);
        cyc();
        check("t5_nocommit2", 64'(debug_wb_pc), 64'd0);
        check("t5_cnt", 64'(retire_cnt), 64'd5);

        // HI/LO-only entry still produces a commit cycle.
        idle();
        in_valid = 1'b1; in_pc = 32'h600; in_hi_we = 1'b1; in_lo_we = 1'b1;
        in_hi_data = 32'h55; in_lo_data = 32'h66;
        cyc();
        idle();
        cyc();
        check("t6_hiwe", 64'(hi_we), 64'd1);
        check("t6_lowe", 64'(lo_we), 64'd1);
        check("t6_hid", 64'(hi_wdata), 64'h55);
        check("t6_lod", 64'(lo_wdata), 64'h66);
        check("t6_rfwe", 64'(rf_we), 64'd0);
        check("t6_pc", 64'(debug_wb_pc), 64'h600);
        check("t6_cnt", 64'(retire_cnt), 64'd5);
        cyc();
        check("t6_pulse", 64'(hi_we), 64'd0);

        // Retire counter wrap with CNT_W=4: 5 + 10 = 15, then +1 wraps to 0.
        burst(10, 32'hC000);
        check("wrap_15", 64'(retire_cnt), 64'd15);
        burst(1, 32'hD000);
        check("wrap_0", 64'(retire_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
